// File: rtl/btb_port_ctrl.sv
// rtl/btb_port_ctrl.sv - single-port BTB RAM arbiter between IF lookups, EX updates and invalidation sweep
// Updates are buffered in a 2-deep FIFO and only steal a RAM cycle from IF when the FIFO is full or IF is idle.
module btb_port_ctrl #(
  parameter  int SIZE  = 1024,
  localparam int INDEX = $clog2(SIZE),
  localparam int TAG   = 30 - INDEX,
  localparam int W     = TAG + 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic             lookup_req,
  input  logic [INDEX-1:0] lookup_idx,
  output logic             lookup_gnt,
  input  logic             upd_valid,
  input  logic [INDEX-1:0] upd_idx,
  input  logic [TAG-1:0]   upd_tag,
  input  logic             upd_jump,
  input  logic [31:0]      upd_target,
  output logic             upd_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic [INDEX-1:0] mem_addr,
  output logic [W-1:0]     mem_wdata,
  output logic             busy
);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t           state;
  logic [INDEX-1:0] sweep_addr;

  logic [INDEX-1:0] q_idx    [2];
  logic [TAG-1:0]   q_tag    [2];
  logic             q_jump   [2];
  logic [31:0]      q_target [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             full;
  logic             push;
  logic             pop;

  always_comb begin
    full       = (count == 2'd2);
    upd_ready  = (state == IDLE) && !full && !flush_req;
    push       = upd_valid && upd_ready;
    pop        = 1'b0;
    lookup_gnt = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    if (state == SWEEP) begin
      busy     = 1'b1;
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = sweep_addr;
    end else if (full || (!lookup_req && count != 2'd0)) begin
      // a full FIFO must drain before IF may read again
      pop       = 1'b1;
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = q_idx[rd_ptr];
      mem_wdata = {1'b1, q_jump[rd_ptr], q_tag[rd_ptr], q_target[rd_ptr]};
    end else if (lookup_req) begin
      lookup_gnt = 1'b1;
      mem_en     = 1'b1;
      mem_addr   = lookup_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SWEEP;
      sweep_addr <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      case (state)
        SWEEP: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == '1) begin
            state      <= IDLE;
            sweep_addr <= '0;
          end
        end
        IDLE: begin
          if (flush_req) begin
            state      <= SWEEP;
            sweep_addr <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
          end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]    <= upd_idx;
      q_tag[wr_ptr]    <= upd_tag;
      q_jump[wr_ptr]   <= upd_jump;
      q_target[wr_ptr] <= upd_target;
    end
  end

endmodule

// File: tb/tb_btb_port_ctrl.sv
// tb/tb_btb_port_ctrl.sv - self-checking bench for btb_port_ctrl (SIZE=16)
module tb_btb_port_ctrl;
  localparam int SIZE  = 16;
  localparam int INDEX = 4;
  localparam int TAG   = 26;
  localparam int W     = 60;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_req;
  logic             lookup_req;
  logic [INDEX-1:0] lookup_idx;
  logic             lookup_gnt;
  logic             upd_valid;
  logic [INDEX-1:0] upd_idx;
  logic [TAG-1:0]   upd_tag;
  logic             upd_jump;
  logic [31:0]      upd_target;
  logic             upd_ready;
  logic             mem_en;
  logic             mem_we;
  logic [INDEX-1:0] mem_addr;
  logic [W-1:0]     mem_wdata;
  logic             busy;

  btb_port_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .lookup_req(lookup_req), .lookup_idx(lookup_idx), .lookup_gnt(lookup_gnt),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_tag(upd_tag), .upd_jump(upd_jump),
    .upd_target(upd_target), .upd_ready(upd_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: pending-update queue plus remaining sweep cycles
  typedef struct packed {
    logic [INDEX-1:0] idx;
    logic [TAG-1:0]   tag;
    logic             jump;
    logic [31:0]      target;
  } upd_t;

  upd_t pend[$];
  int   sweep_left;
  logic e_gnt, e_ready, e_en, e_we, e_busy, e_pop;
  logic [INDEX-1:0] e_addr;
  logic [W-1:0]     e_wdata;

  function automatic void model_reset();
    sweep_left = SIZE;
    pend.delete();
  endfunction

  function automatic void predict();
    e_gnt = 0; e_ready = 0; e_en = 0; e_we = 0; e_busy = 0; e_pop = 0;
    e_addr = '0; e_wdata = '0;
    if (sweep_left > 0) begin
      e_busy = 1; e_en = 1; e_we = 1;
      e_addr = INDEX'(SIZE - sweep_left);
    end else begin
      e_ready = (pend.size() < 2) && !flush_req;
      if (pend.size() == 2) e_pop = 1;
      else if (lookup_req) begin
        e_gnt = 1; e_en = 1; e_addr = lookup_idx;
      end else if (pend.size() > 0) e_pop = 1;
      if (e_pop) begin
        e_en = 1; e_we = 1; e_addr = pend[0].idx;
        e_wdata = {1'b1, pend[0].jump, pend[0].tag, pend[0].target};
      end
    end
  endfunction

  function automatic void advance();
    upd_t u;
    if (rst) model_reset();
    else if (sweep_left > 0) sweep_left--;
    else begin
      if (e_pop) void'(pend.pop_front());
      if (e_ready && upd_valid) begin
        u.idx = upd_idx; u.tag = upd_tag; u.jump = upd_jump; u.target = upd_target;
        pend.push_back(u);
      end
      if (flush_req) model_reset();
    end
  endfunction

  task automatic check_model();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("upd_ready", 64'(upd_ready), 64'(e_ready));
    chk("lookup_gnt", 64'(lookup_gnt), 64'(e_gnt));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
  endtask

  task automatic tick();
    predict();
    @(posedge clk); #1;
    advance();
  endtask

  task automatic step(input bit check);
    #2;
    predict();
    if (check) check_model();
    @(posedge clk); #1;
    advance();
  endtask

  typedef struct {
    logic             lreq;
    logic [INDEX-1:0] lidx;
    logic             uv;
    logic [INDEX-1:0] uidx;
    logic [TAG-1:0]   utag;
    logic             uj;
    logic [31:0]      ut;
    logic             gnt;
    logic             ready;
    logic             en;
    logic             we;
    logic [INDEX-1:0] addr;
    logic [W-1:0]     wdata;
  } vec_t;

  vec_t tbl[8];
  int   bad_writes;
  int   busy_cnt;

  initial begin
    tbl[0] = '{1'b1, 4'd3, 1'b1, 4'd2, 26'h11,  1'b1, 32'h100,  1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 60'd0};
    tbl[1] = '{1'b1, 4'd4, 1'b1, 4'd9, 26'h22,  1'b0, 32'h200,  1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 60'd0};
    tbl[2] = '{1'b1, 4'd6, 1'b0, 4'd0, 26'h0,   1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 4'd2, {1'b1, 1'b1, 26'h11, 32'h100}};
    tbl[3] = '{1'b1, 4'd7, 1'b0, 4'd0, 26'h0,   1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 60'd0};
    tbl[4] = '{1'b0, 4'd0, 1'b1, 4'd1, 26'h33,  1'b1, 32'h300,  1'b0, 1'b1, 1'b1, 1'b1, 4'd9, {1'b1, 1'b0, 26'h22, 32'h200}};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 4'd5, 26'h123, 1'b0, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, {1'b1, 1'b1, 26'h33, 32'h300}};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 4'd0, 26'h0,   1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 4'd5, {1'b1, 1'b0, 26'h123, 32'h1000}};
    tbl[7] = '{1'b0, 4'd0, 1'b0, 4'd0, 26'h0,   1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 60'd0};

    rst = 1'b1; flush_req = 0; lookup_req = 0; lookup_idx = '0;
    upd_valid = 0; upd_idx = '0; upd_tag = '0; upd_jump = 0; upd_target = '0;
    model_reset();

    // outputs while reset is held
    @(posedge clk); #3;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_en", 64'(mem_en), 64'd1);
    chk("rst_we", 64'(mem_we), 64'd1);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_gnt", 64'(lookup_gnt), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // initial sweep over addresses 0..15
    for (int i = 0; i < SIZE; i++) begin
      #2;
      chk("sweep_addr", 64'(mem_addr), 64'(i));
      chk("sweep_busy", 64'(busy), 64'd1);
      chk("sweep_we", 64'(mem_we), 64'd1);
      chk("sweep_wdata", 64'(mem_wdata), 64'd0);
      chk("sweep_ready", 64'(upd_ready), 64'd0);
      tick();
    end
    #2;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(upd_ready), 64'd1);
    chk("idle_en", 64'(mem_en), 64'd0);
    tick();

    // directed arbitration vectors
    for (int i = 0; i < 8; i++) begin
      lookup_req = tbl[i].lreq; lookup_idx = tbl[i].lidx;
      upd_valid = tbl[i].uv; upd_idx = tbl[i].uidx; upd_tag = tbl[i].utag;
      upd_jump = tbl[i].uj; upd_target = tbl[i].ut;
      #2;
      chk($sformatf("vec%0d_gnt", i), 64'(lookup_gnt), 64'(tbl[i].gnt));
      chk($sformatf("vec%0d_ready", i), 64'(upd_ready), 64'(tbl[i].ready));
      chk($sformatf("vec%0d_en", i), 64'(mem_en), 64'(tbl[i].en));
      chk($sformatf("vec%0d_we", i), 64'(mem_we), 64'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
      chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(tbl[i].wdata));
      tick();
    end

    // flush drops a pending update
    lookup_req = 1; lookup_idx = 4'd0;
    upd_valid = 1; upd_idx = 4'd10; upd_tag = 26'h3ff; upd_jump = 1; upd_target = 32'hdead_beef;
    step(1);
    upd_valid = 0; flush_req = 1;
    step(1);
    flush_req = 0;
    bad_writes = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      predict();
      check_model();
      if (busy) busy_cnt++;
      if (mem_we && mem_wdata != '0) bad_writes++;
      @(posedge clk); #1;
      advance();
    end
    chk("flush_discard", 64'(bad_writes), 64'd0);
    chk("flush_busy_cycles", 64'(busy_cnt), 64'(SIZE));

    // asynchronous reset in mid-sweep
    lookup_req = 0;
    rst = 1; model_reset();
    step(1);
    rst = 0;
    for (int i = 0; i < 7; i++) step(1);
    #2;
    chk("pre_rst_addr", 64'(mem_addr), 64'd7);
    rst = 1; model_reset();
    #1;
    chk("async_rst_addr", 64'(mem_addr), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < SIZE + 2; i++) step(1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      lookup_req = ($urandom_range(0, 9) < 7);
      lookup_idx = INDEX'($urandom);
      upd_valid  = 1'($urandom_range(0, 1));
      upd_idx    = INDEX'($urandom);
      upd_tag    = TAG'($urandom);
      upd_jump   = 1'($urandom);
      upd_target = $urandom;
      flush_req  = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      if (rst) model_reset();
      step(1);
      rst = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
